// File: rtl/dsm_mash_wb_if.sv
// Wishbone classic/pipelined slave bundle for the MASH modulator.
// Signal names keep the bus-side i_/o_ view of the slave.
interface dsm_mash_wb_if;
   logic        i_wb_cyc;
   logic        i_wb_stb;
   logic        i_wb_we;
   logic [31:0] i_wb_addr;
   logic [31:0] i_wb_data;
   logic        o_wb_ack;
   logic        o_wb_stall;
   logic [31:0] o_wb_data;

   modport slave (
      input  i_wb_cyc,
      input  i_wb_stb,
      input  i_wb_we,
      input  i_wb_addr,
      input  i_wb_data,
      output o_wb_ack,
      output o_wb_stall,
      output o_wb_data
   );

   modport master (
      output i_wb_cyc,
      output i_wb_stb,
      output i_wb_we,
      output i_wb_addr,
      output i_wb_data,
      input  o_wb_ack,
      input  o_wb_stall,
      input  o_wb_data
   );
endinterface

// File: rtl/dsm_mash_wb.sv
// MASH 1/2/3 delta-sigma modulator with Wishbone configuration.
// Cascaded first-order accumulators advance once per divider tick; the
// carries are combined into a signed multi-level sample in dsm_out.
// Register map (byte offsets from BASE_ADDR):
//   +0x0 CTRL   bit0 EN, bits[2:1] ORDER (0/1 -> 1, 2 -> 2, 3 -> 3)
//   +0x4 DATA   IN_W-bit shadow input word
//   +0x8 DIV    DIV_W-bit tick divider
//   +0xC STATUS bits[OUT_W-1:0] dsm_out, bits[31:16] sample counter
module dsm_mash_wb #(
   parameter int unsigned IN_W      = 16,
   parameter int unsigned OUT_W     = 4,
   parameter int unsigned DIV_W     = 16,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic             clk,
   input  logic             reset,
   dsm_mash_wb_if.slave     wb,
   output logic [OUT_W-1:0] dsm_out,
   output logic             dsm_valid
);

   localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [15:0]      CNT_ONE = 16'h0001;

   // Zero-extend a single carry bit to the output sample width.
   function automatic logic [OUT_W-1:0] bit_ext(input logic b);
      bit_ext = {{(OUT_W-1){1'b0}}, b};
   endfunction

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic             ack_r;
   logic [31:0]      rdata_r;
   logic             en_r;
   logic [1:0]       order_r;
   logic [IN_W-1:0]  shadow_r;
   logic [DIV_W-1:0] div_r;
   logic [DIV_W-1:0] div_cnt_r;
   logic [IN_W-1:0]  a1_r;
   logic [IN_W-1:0]  a2_r;
   logic [IN_W-1:0]  a3_r;
   logic             c2_d1_r;
   logic             c3_d1_r;
   logic             c3_d2_r;
   logic [OUT_W-1:0] dsm_out_r;
   logic             dsm_valid_r;
   logic [15:0]      sample_cnt_r;

   // ------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------
   logic             req_s;
   logic             addr_hit_s;
   logic [1:0]       reg_sel_s;
   logic             wr_ctrl_s;
   logic             wr_data_s;
   logic             wr_div_s;
   logic             srst_s;
   logic             tick_s;
   logic             stage2_on_s;
   logic             stage3_on_s;
   logic [IN_W:0]    sum1_s;
   logic [IN_W:0]    sum2_s;
   logic [IN_W:0]    sum3_s;
   logic             c1_s;
   logic             c2_s;
   logic             c3_s;
   logic [OUT_W-1:0] y_s;
   logic [31:0]      status_s;
   logic [31:0]      rdata_s;
   logic             wdata_unused_s;

   // Only the low bits of the write word reach the registers.
   assign wdata_unused_s = ^wb.i_wb_data;

   // Address decode and write strobes; STATUS and unmapped writes are dropped.
   always_comb begin
      req_s      = wb.i_wb_cyc & wb.i_wb_stb;
      addr_hit_s = (wb.i_wb_addr[31:4] == BASE_ADDR[31:4]) &&
                   (wb.i_wb_addr[1:0] == 2'b00);
      reg_sel_s  = wb.i_wb_addr[3:2];
      wr_ctrl_s  = 1'b0;
      wr_data_s  = 1'b0;
      wr_div_s   = 1'b0;
      if (req_s && wb.i_wb_we && addr_hit_s) begin
         case (reg_sel_s)
            2'b00:   wr_ctrl_s = 1'b1;
            2'b01:   wr_data_s = 1'b1;
            2'b10:   wr_div_s  = 1'b1;
            default: wr_ctrl_s = 1'b0;
         endcase
      end else begin
         wr_ctrl_s = 1'b0;
      end
   end

   // Mode-change clear and tick qualification. A CTRL write that changes
   // ORDER or clears EN restarts the modulator; a tick coinciding with
   // that write is swallowed so the next tick starts from clean state.
   always_comb begin
      srst_s      = wr_ctrl_s &&
                    ((wb.i_wb_data[2:1] != order_r) || !wb.i_wb_data[0]);
      tick_s      = en_r && (div_cnt_r == div_r) && !srst_s;
      stage2_on_s = order_r[1];
      stage3_on_s = order_r[1] & order_r[0];
   end

   // Accumulator chain: each stage integrates the new sum of the stage
   // before it within the same tick. The shadow word feeds stage 1 at
   // the tick, so it is the active input for that accumulation.
   always_comb begin
      sum1_s = {1'b0, a1_r} + {1'b0, shadow_r};
      if (stage2_on_s) begin
         sum2_s = {1'b0, a2_r} + {1'b0, sum1_s[IN_W-1:0]};
      end else begin
         sum2_s = '0;
      end
      if (stage3_on_s) begin
         sum3_s = {1'b0, a3_r} + {1'b0, sum2_s[IN_W-1:0]};
      end else begin
         sum3_s = '0;
      end
      c1_s = sum1_s[IN_W];
      c2_s = sum2_s[IN_W];
      c3_s = sum3_s[IN_W];
   end

   // Noise-cancelling recombination in modular OUT_W arithmetic; the
   // bit pattern is the two's-complement sample. Disabled stages hold
   // zero carries and zero history, so one expression covers all orders.
   always_comb begin
      y_s = bit_ext(c1_s)
          + bit_ext(c2_s) - bit_ext(c2_d1_r)
          + bit_ext(c3_s) - bit_ext(c3_d1_r) - bit_ext(c3_d1_r)
          + bit_ext(c3_d2_r);
   end

   // Readback multiplexer; unmapped addresses and unused bits read zero.
   always_comb begin
      status_s              = '0;
      status_s[OUT_W-1:0]   = dsm_out_r;
      status_s[31:16]       = sample_cnt_r;
      rdata_s               = '0;
      if (addr_hit_s) begin
         case (reg_sel_s)
            2'b00:   rdata_s = {29'b0, order_r, en_r};
            2'b01:   rdata_s[IN_W-1:0]  = shadow_r;
            2'b10:   rdata_s[DIV_W-1:0] = div_r;
            2'b11:   rdata_s = status_s;
            default: rdata_s = '0;
         endcase
      end else begin
         rdata_s = '0;
      end
   end

   // Bus response: one-cycle ack for every request, read data registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_r   <= 1'b0;
         rdata_r <= '0;
      end else begin
         ack_r <= req_s;
         if (req_s && !wb.i_wb_we) begin
            rdata_r <= rdata_s;
         end else begin
            rdata_r <= '0;
         end
      end
   end

   // Configuration registers written from the bus.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_r     <= 1'b0;
         order_r  <= 2'b00;
         shadow_r <= '0;
         div_r    <= '0;
      end else begin
         if (wr_ctrl_s) begin
            en_r    <= wb.i_wb_data[0];
            order_r <= wb.i_wb_data[2:1];
         end
         if (wr_data_s) begin
            shadow_r <= wb.i_wb_data[IN_W-1:0];
         end
         if (wr_div_s) begin
            div_r <= wb.i_wb_data[DIV_W-1:0];
         end
      end
   end

   // Sample-rate divider: counts 0..DIV while enabled, restarts on a DIV
   // write, on a mode change, and after each tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt_r <= '0;
      end else if (srst_s || wr_div_s || tick_s || !en_r) begin
         div_cnt_r <= '0;
      end else begin
         div_cnt_r <= div_cnt_r + DIV_ONE;
      end
   end

   // Modulator state: accumulators, carry history, output sample, valid
   // pulse and the free-running sample counter advance only on ticks.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a1_r         <= '0;
         a2_r         <= '0;
         a3_r         <= '0;
         c2_d1_r      <= 1'b0;
         c3_d1_r      <= 1'b0;
         c3_d2_r      <= 1'b0;
         dsm_out_r    <= '0;
         dsm_valid_r  <= 1'b0;
         sample_cnt_r <= '0;
      end else if (srst_s) begin
         a1_r        <= '0;
         a2_r        <= '0;
         a3_r        <= '0;
         c2_d1_r     <= 1'b0;
         c3_d1_r     <= 1'b0;
         c3_d2_r     <= 1'b0;
         dsm_out_r   <= '0;
         dsm_valid_r <= 1'b0;
      end else if (tick_s) begin
         a1_r         <= sum1_s[IN_W-1:0];
         a2_r         <= sum2_s[IN_W-1:0];
         a3_r         <= sum3_s[IN_W-1:0];
         c2_d1_r      <= c2_s;
         c3_d1_r      <= c3_s;
         c3_d2_r      <= c3_d1_r;
         dsm_out_r    <= y_s;
         dsm_valid_r  <= 1'b1;
         sample_cnt_r <= sample_cnt_r + CNT_ONE;
      end else begin
         dsm_valid_r <= 1'b0;
      end
   end

   assign wb.o_wb_ack   = ack_r;
   assign wb.o_wb_stall = 1'b0;
   assign wb.o_wb_data  = rdata_r;
   assign dsm_out       = dsm_out_r;
   assign dsm_valid     = dsm_valid_r;

endmodule

// File: tb/tb_dsm_mash_wb.sv
// Directed bench for dsm_mash_wb: a register-access table followed by
// hand-computed modulator sequences (order 1/2/3, divider, shadow timing).
module tb_dsm_mash_wb;

   localparam logic [31:0] BASE   = 32'h3000_0000;
   localparam logic [31:0] A_CTRL = BASE;
   localparam logic [31:0] A_DATA = BASE + 32'h4;
   localparam logic [31:0] A_DIV  = BASE + 32'h8;
   localparam logic [31:0] A_STAT = BASE + 32'hC;
   localparam logic [31:0] A_BAD  = BASE + 32'h10;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;   // write data, or expected read data
      string       name;
   } vec_t;

   logic       clk;
   logic       reset;
   logic [3:0] dsm_out;
   logic       dsm_valid;
   int         errors = 0;
   int         checks = 0;

   dsm_mash_wb_if wb();

   dsm_mash_wb #(
      .IN_W(16), .OUT_W(4), .DIV_W(16), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .wb(wb),
      .dsm_out(dsm_out),
      .dsm_valid(dsm_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_write(input logic [31:0] addr, input logic [31:0] data, input string name);
      wb.i_wb_cyc  = 1'b1;
      wb.i_wb_stb  = 1'b1;
      wb.i_wb_we   = 1'b1;
      wb.i_wb_addr = addr;
      wb.i_wb_data = data;
      step();
      chk({name, "_ack"}, 32'(wb.o_wb_ack), 32'd1);
      wb.i_wb_cyc = 1'b0;
      wb.i_wb_stb = 1'b0;
      wb.i_wb_we  = 1'b0;
   endtask

   task automatic wb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
      wb.i_wb_cyc  = 1'b1;
      wb.i_wb_stb  = 1'b1;
      wb.i_wb_we   = 1'b0;
      wb.i_wb_addr = addr;
      step();
      chk({name, "_ack"}, 32'(wb.o_wb_ack), 32'd1);
      chk({name, "_data"}, wb.o_wb_data, exp);
      wb.i_wb_cyc = 1'b0;
      wb.i_wb_stb = 1'b0;
      step();
      chk({name, "_ack_drop"}, 32'(wb.o_wb_ack), 32'd0);
   endtask

   vec_t       vecs [18];
   logic [3:0] o1_exp [8];
   logic [3:0] o3_exp [4];
   logic [3:0] o2_exp [4];
   logic [3:0] sh_exp [4];

   initial begin
      int sum;
      int v;
      int nval;
      int oor;
      int nz;

      o1_exp = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1};
      o3_exp = '{4'h0, 4'h2, 4'hF, 4'h1};
      o2_exp = '{4'h0, 4'h1, 4'h1, 4'h0};
      sh_exp = '{4'h1, 4'h1, 4'h0, 4'h1};

      vecs[0]  = '{1'b0, A_CTRL, 32'h0000_0000, "rd_ctrl_rst"};
      vecs[1]  = '{1'b0, A_DATA, 32'h0000_0000, "rd_data_rst"};
      vecs[2]  = '{1'b0, A_DIV,  32'h0000_0000, "rd_div_rst"};
      vecs[3]  = '{1'b0, A_STAT, 32'h0000_0000, "rd_stat_rst"};
      vecs[4]  = '{1'b1, A_DATA, 32'hFFFF_1234, "wr_data"};
      vecs[5]  = '{1'b0, A_DATA, 32'h0000_1234, "rd_data"};
      vecs[6]  = '{1'b1, A_DIV,  32'h0001_ABCD, "wr_div"};
      vecs[7]  = '{1'b0, A_DIV,  32'h0000_ABCD, "rd_div"};
      vecs[8]  = '{1'b1, A_CTRL, 32'hFFFF_FFF6, "wr_ctrl"};
      vecs[9]  = '{1'b0, A_CTRL, 32'h0000_0006, "rd_ctrl"};
      vecs[10] = '{1'b1, A_BAD,  32'hFFFF_FFFF, "wr_unmapped"};
      vecs[11] = '{1'b1, A_STAT, 32'hFFFF_FFFF, "wr_status"};
      vecs[12] = '{1'b0, A_BAD,  32'h0000_0000, "rd_unmapped"};
      vecs[13] = '{1'b0, A_CTRL, 32'h0000_0006, "rd_ctrl_kept"};
      vecs[14] = '{1'b0, A_DATA, 32'h0000_1234, "rd_data_kept"};
      vecs[15] = '{1'b0, A_DIV,  32'h0000_ABCD, "rd_div_kept"};
      vecs[16] = '{1'b0, A_STAT, 32'h0000_0000, "rd_stat_kept"};
      vecs[17] = '{1'b0, 32'h0000_0004, 32'h0000_0000, "rd_other_base"};

      wb.i_wb_cyc  = 1'b0;
      wb.i_wb_stb  = 1'b0;
      wb.i_wb_we   = 1'b0;
      wb.i_wb_addr = 32'h0;
      wb.i_wb_data = 32'h0;
      reset        = 1'b0;

      // Reset state
      #1;
      chk("rst_ack",   32'(wb.o_wb_ack), 32'd0);
      chk("rst_rdata", wb.o_wb_data, 32'd0);
      chk("rst_out",   32'(dsm_out), 32'd0);
      chk("rst_valid", 32'(dsm_valid), 32'd0);
      chk("rst_stall", 32'(wb.o_wb_stall), 32'd0);
      step();
      step();
      reset = 1'b1;
      step();

      // Register access table
      for (int i = 0; i < 18; i++) begin
         if (vecs[i].we) begin
            wb_write(vecs[i].addr, vecs[i].data, vecs[i].name);
         end else begin
            wb_read(vecs[i].addr, vecs[i].data, vecs[i].name);
         end
      end

      // Order 1, DIV=0: 0x4000 gives a carry every fourth tick
      wb_write(A_DATA, 32'h0000_4000, "o1_data");
      wb_write(A_DIV,  32'h0000_0000, "o1_div");
      wb_write(A_CTRL, 32'h0000_0003, "o1_ctrl");
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("o1_valid%0d", i), 32'(dsm_valid), 32'd1);
         chk($sformatf("o1_out%0d", i), 32'(dsm_out), 32'(o1_exp[i]));
      end

      // Asynchronous reset in the middle of a stream
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_valid", 32'(dsm_valid), 32'd0);
      chk("midrst_out",   32'(dsm_out), 32'd0);
      step();
      reset = 1'b1;
      wb_read(A_CTRL, 32'h0, "midrst_ctrl");
      wb_read(A_DATA, 32'h0, "midrst_data");
      wb_read(A_STAT, 32'h0, "midrst_stat");

      // Divider: DIV=3 -> one tick every 4 cycles
      wb_write(A_DATA, 32'h0000_4000, "dv_data");
      wb_write(A_DIV,  32'h0000_0003, "dv_div");
      wb_write(A_CTRL, 32'h0000_0001, "dv_ctrl");
      for (int k = 1; k <= 20; k++) begin
         step();
         chk($sformatf("dv_valid%0d", k), 32'(dsm_valid), ((k % 4) == 0) ? 32'd1 : 32'd0);
         if ((k % 4) == 0) begin
            chk($sformatf("dv_out%0d", k), 32'(dsm_out), 32'(o1_exp[k/4 - 1]));
         end
      end
      wb_read(A_STAT, 32'h0005_0000, "dv_stat");

      // Disable: output cleared, no ticks
      wb_write(A_CTRL, 32'h0000_0000, "dis_ctrl");
      chk("dis_out", 32'(dsm_out), 32'd0);
      nval = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (dsm_valid) nval++;
      end
      chk("dis_nvalid", 32'(nval), 32'd0);

      // Order 3 with zero input stays at zero
      wb_write(A_DATA, 32'h0000_0000, "o3z_data");
      wb_write(A_DIV,  32'h0000_0000, "o3z_div");
      wb_write(A_CTRL, 32'h0000_0007, "o3z_ctrl");
      nval = 0;
      nz   = 0;
      for (int k = 0; k < 32; k++) begin
         step();
         if (dsm_valid) nval++;
         if (dsm_out != 4'h0) nz++;
      end
      chk("o3z_nvalid",  32'(nval), 32'd32);
      chk("o3z_nonzero", 32'(nz), 32'd0);

      // Order 3, DATA=0x8000: mean 1/2, 256-tick sum 128, range -3..+4
      wb_write(A_DATA, 32'h0000_8000, "o3_data");
      nval = 0;
      sum  = 0;
      oor  = 0;
      for (int k = 0; k < 256; k++) begin
         step();
         if (dsm_valid) nval++;
         v = $signed(dsm_out);
         sum += v;
         if (v < -3 || v > 4) oor++;
         if (k < 4) chk($sformatf("o3_out%0d", k), 32'(dsm_out), 32'(o3_exp[k]));
      end
      chk("o3_nvalid", 32'(nval), 32'd256);
      chk("o3_sum",    32'(sum), 32'd128);
      chk("o3_range",  32'(oor), 32'd0);

      // Switch to order 2 mid-stream: cleared, then restart
      wb_write(A_CTRL, 32'h0000_0005, "o2_ctrl");
      chk("o2_clr_valid", 32'(dsm_valid), 32'd0);
      chk("o2_clr_out",   32'(dsm_out), 32'd0);
      nval = 0;
      sum  = 0;
      oor  = 0;
      for (int k = 0; k < 64; k++) begin
         step();
         if (dsm_valid) nval++;
         v = $signed(dsm_out);
         sum += v;
         if (v < -1 || v > 2) oor++;
         if (k < 4) chk($sformatf("o2_out%0d", k), 32'(dsm_out), 32'(o2_exp[k]));
      end
      chk("o2_nvalid", 32'(nval), 32'd64);
      chk("o2_sum",    32'(sum), 32'd32);
      chk("o2_range",  32'(oor), 32'd0);

      // Shadow timing: DATA write landing on a tick takes effect one tick later
      wb_write(A_DATA, 32'h0000_4000, "sh_data0");
      wb_write(A_CTRL, 32'h0000_0003, "sh_ctrl");
      step();
      chk("sh_t1_valid", 32'(dsm_valid), 32'd1);
      chk("sh_t1_out",   32'(dsm_out), 32'd0);
      wb_write(A_DATA, 32'h0000_C000, "sh_data1");
      chk("sh_t2_valid", 32'(dsm_valid), 32'd1);
      chk("sh_t2_out",   32'(dsm_out), 32'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("sh_t%0d_out", k + 3), 32'(dsm_out), 32'(sh_exp[k]));
      end
      wb_read(A_DATA, 32'h0000_C000, "sh_rd_data");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
